rr_bus_arbiter: RTL and testbench

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/rr_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle all-low HANDOVER turnaround between owners.
// Define RR_ARB_TIMEOUT_EN to let a contended owner be revoked after TIMEOUT_CYCLES grant cycles.
module rr_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ID_W           = 2
) (
    input  logic                   clk,
    input  logic                   bReset,
    input  logic [NUM_MASTERS-1:0] Breq,
    output logic [NUM_MASTERS-1:0] Bgnt,
    output logic                   BusBusy,
    output logic [ID_W-1:0]        GntId,
    output logic                   Timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

    state_t                 state;
    logic [ID_W-1:0]        last_owner;
    logic [ID_W-1:0]        winner;
    logic [NUM_MASTERS-1:0] winner_onehot;
    logic                   found;
    int                     idx;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > 255 || (1 << ID_W) < NUM_MASTERS) begin : g_param_check
        $error("rr_bus_arbiter: illegal parameter combination");
    end

    // First requester at or after last_owner+1, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_owner) + k) % NUM_MASTERS;
            if (!found && Breq[ID_W'(idx)]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign winner_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] TENURE_MAX = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tenure;
    logic       other_req;

    assign other_req = |(Breq & ~Bgnt);

    always_ff @(posedge clk or negedge bReset) begin
        if (!bReset) begin
            state      <= IDLE;
            Bgnt       <= '0;
            BusBusy    <= 1'b0;
            GntId      <= '0;
            Timeout    <= 1'b0;
            tenure     <= '0;
            last_owner <= ID_W'(NUM_MASTERS - 1);
        end else begin
            Timeout <= 1'b0;
            case (state)
                IDLE, HANDOVER: begin
                    if (|Breq) begin
                        state   <= GRANT;
                        Bgnt    <= winner_onehot;
                        BusBusy <= 1'b1;
                        GntId   <= winner;
                        tenure  <= '0;
                    end else begin
                        state   <= IDLE;
                        Bgnt    <= '0;
                        BusBusy <= 1'b0;
                    end
                end
                GRANT: begin
                    // Owner release takes precedence over a coincident revocation.
                    if (!Breq[GntId]) begin
                        state      <= HANDOVER;
                        Bgnt       <= '0;
                        BusBusy    <= 1'b0;
                        last_owner <= GntId;
                    end else if (tenure == TENURE_MAX && other_req) begin
                        state      <= HANDOVER;
                        Bgnt       <= '0;
                        BusBusy    <= 1'b0;
                        last_owner <= GntId;
                        Timeout    <= 1'b1;
                    end else if (tenure != TENURE_MAX) begin
                        tenure <= tenure + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Bgnt    <= '0;
                    BusBusy <= 1'b0;
                end
            endcase
        end
    end
`else
    assign Timeout = 1'b0;

    always_ff @(posedge clk or negedge bReset) begin
        if (!bReset) begin
            state      <= IDLE;
            Bgnt       <= '0;
            BusBusy    <= 1'b0;
            GntId      <= '0;
            last_owner <= ID_W'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE, HANDOVER: begin
                    if (|Breq) begin
                        state   <= GRANT;
                        Bgnt    <= winner_onehot;
                        BusBusy <= 1'b1;
                        GntId   <= winner;
                    end else begin
                        state   <= IDLE;
                        Bgnt    <= '0;
                        BusBusy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!Breq[GntId]) begin
                        state      <= HANDOVER;
                        Bgnt       <= '0;
                        BusBusy    <= 1'b0;
                        last_owner <= GntId;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Bgnt    <= '0;
                    BusBusy <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed testbench for rr_bus_arbiter (NUM_MASTERS=4, TIMEOUT_CYCLES=16).
// Expectations follow RR_ARB_TIMEOUT_EN when the bench is built with it defined.
module tb_rr_bus_arbiter;

    logic       clk;
    logic       bReset;
    logic [3:0] Breq;
    logic [3:0] Bgnt;
    logic       BusBusy;
    logic [1:0] GntId;
    logic       Timeout;

    int total;
    int bad;

    rr_bus_arbiter #(
        .NUM_MASTERS(4),
        .TIMEOUT_CYCLES(16),
        .ID_W(2)
    ) dut (
        .clk(clk),
        .bReset(bReset),
        .Breq(Breq),
        .Bgnt(Bgnt),
        .BusBusy(BusBusy),
        .GntId(GntId),
        .Timeout(Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bReset = 1'b0;
        Breq   = 4'b0000;
        tick();
        tick();
        bReset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        bReset = 1'b0;
        #1;
        total++; if (Bgnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_bgnt got=%b exp=0000", Bgnt); end
        total++; if (BusBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", BusBusy); end
        total++; if (GntId !== 2'd0) begin bad++; $display("[TB] FAIL reset_gntid got=%0d exp=0", GntId); end
        total++; if (Timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout got=%b exp=0", Timeout); end
        tick();
        bReset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        Breq = 4'b0100;
        tick();
        total++; if (Bgnt !== 4'b0100) begin bad++; $display("[TB] FAIL single_bgnt got=%b exp=0100", Bgnt); end
        total++; if (GntId !== 2'd2) begin bad++; $display("[TB] FAIL single_gntid got=%0d exp=2", GntId); end
        total++; if (BusBusy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%b exp=1", BusBusy); end
        Breq = 4'b0000;
        tick();
        total++; if (Bgnt !== 4'b0000) begin bad++; $display("[TB] FAIL single_drop got=%b exp=0000", Bgnt); end
        total++; if (BusBusy !== 1'b0) begin bad++; $display("[TB] FAIL single_drop_busy got=%b exp=0", BusBusy); end
        tick();
        total++; if (GntId !== 2'd2) begin bad++; $display("[TB] FAIL single_gntid_hold got=%0d exp=2", GntId); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int         e;
        do_reset();
        Breq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            e       = i % 4;
            exp_gnt = 4'b0001 << e;
            tick();
            total++; if (Bgnt !== exp_gnt) begin bad++; $display("[TB] FAIL rr_grant%0d got=%b exp=%b", i, Bgnt, exp_gnt); end
            total++; if (GntId !== 2'(e)) begin bad++; $display("[TB] FAIL rr_id%0d got=%0d exp=%0d", i, GntId, e); end
            tick();
            tick();
            total++; if (Bgnt !== exp_gnt) begin bad++; $display("[TB] FAIL rr_hold%0d got=%b exp=%b", i, Bgnt, exp_gnt); end
            Breq = 4'b1111 & ~exp_gnt;
            tick();
            total++; if (Bgnt !== 4'b0000) begin bad++; $display("[TB] FAIL rr_handover%0d got=%b exp=0000", i, Bgnt); end
            Breq = 4'b1111;
        end
        Breq = 4'b0000;
        tick();
    endtask

    task automatic test_mid_tenure();
        do_reset();
        Breq = 4'b0010;
        tick();
        total++; if (Bgnt !== 4'b0010) begin bad++; $display("[TB] FAIL mid_grant got=%b exp=0010", Bgnt); end
        tick();
        Breq = 4'b1010;
        tick();
        tick();
        total++; if (Bgnt !== 4'b0010) begin bad++; $display("[TB] FAIL mid_unchanged got=%b exp=0010", Bgnt); end
        Breq = 4'b1000;
        tick();
        total++; if (Bgnt !== 4'b0000) begin bad++; $display("[TB] FAIL mid_handover got=%b exp=0000", Bgnt); end
        total++; if (GntId !== 2'd1) begin bad++; $display("[TB] FAIL mid_handover_id got=%0d exp=1", GntId); end
        tick();
        total++; if (Bgnt !== 4'b1000) begin bad++; $display("[TB] FAIL mid_next got=%b exp=1000", Bgnt); end
        total++; if (GntId !== 2'd3) begin bad++; $display("[TB] FAIL mid_next_id got=%0d exp=3", GntId); end
        Breq = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int         held_bad;
        logic [3:0] exp_gnt;
        logic       exp_to;
        do_reset();
        Breq = 4'b0101;
        tick();
        held_bad = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (Bgnt !== 4'b0001 || Timeout !== 1'b0) held_bad++;
        end
        total++; if (held_bad !== 0) begin bad++; $display("[TB] FAIL to_tenure got=%0d bad cycles exp=0", held_bad); end
        tick();
`ifdef RR_ARB_TIMEOUT_EN
        exp_gnt = 4'b0000;
        exp_to  = 1'b1;
`else
        exp_gnt = 4'b0001;
        exp_to  = 1'b0;
`endif
        total++; if (Bgnt !== exp_gnt) begin bad++; $display("[TB] FAIL to_revoke got=%b exp=%b", Bgnt, exp_gnt); end
        total++; if (Timeout !== exp_to) begin bad++; $display("[TB] FAIL to_pulse got=%b exp=%b", Timeout, exp_to); end
        tick();
`ifdef RR_ARB_TIMEOUT_EN
        exp_gnt = 4'b0100;
`else
        exp_gnt = 4'b0001;
`endif
        total++; if (Bgnt !== exp_gnt) begin bad++; $display("[TB] FAIL to_next got=%b exp=%b", Bgnt, exp_gnt); end
        total++; if (Timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_pulse_end got=%b exp=0", Timeout); end
    endtask

    task automatic test_solo_hold();
        int held_bad;
        do_reset();
        Breq = 4'b0001;
        held_bad = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (Bgnt !== 4'b0001 || Timeout !== 1'b0) held_bad++;
        end
        total++; if (held_bad !== 0) begin bad++; $display("[TB] FAIL solo_hold got=%0d bad cycles exp=0", held_bad); end
    endtask

    task automatic test_release_vs_revoke();
        do_reset();
        Breq = 4'b0101;
        tick();
        for (int k = 1; k < 16; k++) tick();
        Breq = 4'b0100;
        tick();
        total++; if (Bgnt !== 4'b0000) begin bad++; $display("[TB] FAIL both_release got=%b exp=0000", Bgnt); end
        total++; if (Timeout !== 1'b0) begin bad++; $display("[TB] FAIL both_timeout got=%b exp=0", Timeout); end
        tick();
        total++; if (Bgnt !== 4'b0100) begin bad++; $display("[TB] FAIL both_next got=%b exp=0100", Bgnt); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        Breq = 4'b0100;
        tick();
        total++; if (GntId !== 2'd2) begin bad++; $display("[TB] FAIL rst_pre_id got=%0d exp=2", GntId); end
        #2;
        bReset = 1'b0;
        #1;
        total++; if (Bgnt !== 4'b0000) begin bad++; $display("[TB] FAIL rst_async_bgnt got=%b exp=0000", Bgnt); end
        total++; if (GntId !== 2'd0) begin bad++; $display("[TB] FAIL rst_async_id got=%0d exp=0", GntId); end
        total++; if (BusBusy !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_busy got=%b exp=0", BusBusy); end
        Breq = 4'b1010;
        tick();
        bReset = 1'b1;
        tick();
        total++; if (Bgnt !== 4'b0010) begin bad++; $display("[TB] FAIL rst_first got=%b exp=0010", Bgnt); end
        total++; if (GntId !== 2'd1) begin bad++; $display("[TB] FAIL rst_first_id got=%0d exp=1", GntId); end
        Breq = 4'b0000;
        tick();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        bReset = 1'b0;
        Breq   = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_mid_tenure();
        test_timeout();
        test_solo_hold();
        test_release_vs_revoke();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
